hex_scan_decoder: RTL and testbench

Passive monitor for the board's multiplexed seven-segment display bus. It watches the segment and grid lines driven by the hex driver and rebuilds the 4-digit hexadecimal value being shown, including the decimal points. It sits beside the Lab 4 multiplier top level in simulation and on-chip debug. Its output lets checks compare displayed results against Aval/Bval directly, without scraping segment patterns.

---
 rtl/hex_scan_pkg.sv | 57 +++++
 rtl/seg7_decode.sv | 14 +
 rtl/hex_scan_decoder.sv | 153 +++++++++++++++
 tb/tb_hex_scan_decoder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_scan_pkg.sv
// Shared definitions for the seven-segment scan monitor: glyph codes, FSM states, glyph lookup.
// Latency: none (constants and a combinational helper only).
// Backpressure: not applicable; the monitor is passive and never stalls the bus it watches.
package hex_scan_pkg;

    // Active-low glyphs {dp,g,f,e,d,c,b,a} with the decimal point off.
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_A     = 8'h88;
    localparam logic [7:0] SEG_B     = 8'h83;
    localparam logic [7:0] SEG_C     = 8'hC6;
    localparam logic [7:0] SEG_D     = 8'hA1;
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_F     = 8'h8E;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SETTLE   = 2'd1,
        ST_CAPTURED = 2'd2
    } scan_state_t;

    // Returns {legal, nibble}; the decimal point is not part of the lookup.
    function automatic logic [4:0] seg_to_nibble(input logic [6:0] seg);
        logic [4:0] res;
        res = 5'b0_0000;
        case (seg)
            SEG_0[6:0]: res = {1'b1, 4'h0};
            SEG_1[6:0]: res = {1'b1, 4'h1};
            SEG_2[6:0]: res = {1'b1, 4'h2};
            SEG_3[6:0]: res = {1'b1, 4'h3};
            SEG_4[6:0]: res = {1'b1, 4'h4};
            SEG_5[6:0]: res = {1'b1, 4'h5};
            SEG_6[6:0]: res = {1'b1, 4'h6};
            SEG_7[6:0]: res = {1'b1, 4'h7};
            SEG_8[6:0]: res = {1'b1, 4'h8};
            SEG_9[6:0]: res = {1'b1, 4'h9};
            SEG_A[6:0]: res = {1'b1, 4'hA};
            SEG_B[6:0]: res = {1'b1, 4'hB};
            SEG_C[6:0]: res = {1'b1, 4'hC};
            SEG_D[6:0]: res = {1'b1, 4'hD};
            SEG_E[6:0]: res = {1'b1, 4'hE};
            SEG_F[6:0]: res = {1'b1, 4'hF};
            default:    res = 5'b0_0000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational seven-segment glyph to hex nibble decoder.
// Latency: zero cycles (pure combinational).
// Backpressure: none; output follows input continuously.
module seg7_decode
    import hex_scan_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic       legal_o,
    output logic [3:0] nibble_o
);

    assign {legal_o, nibble_o} = seg_to_nibble(seg_i);

endmodule

// File: rtl/hex_scan_decoder.sv
// Passive monitor rebuilding the 4-digit hex value and decimal points from a multiplexed 7-seg bus.
// Latency: capture SETTLE_CYCLES-1 edges after a grid first appears; outputs visible one cycle later.
// Backpressure: none; the bus is only observed, glitchy or invalid grid dwells are ignored.
module hex_scan_decoder
    import hex_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [7:0]  hex_seg_i,
    input  logic [3:0]  hex_grid_i,
    output logic [15:0] value_o,
    output logic [3:0]  dp_o,
    output logic        frame_valid_o,
    output logic        decode_err_o
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYCLES - 1);
    // cnt holds (samples seen - 1); the capture edge is the one that brings samples to SETTLE_CYCLES.
    localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(SETTLE_CYCLES - 2);

    scan_state_t      state_q, state_d;
    logic [3:0]       grid_prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      shadow_q, shadow_d;
    logic [3:0]       sdp_q, sdp_d;
    logic [3:0]       seen_q, seen_d;
    logic [15:0]      value_q, value_d;
    logic [3:0]       dp_q, dp_d;
    logic             fv_q, fv_d;
    logic             err_q, err_d;

    logic             grid_ok;
    logic             grid_same;
    logic             capture;
    logic [1:0]       dig_idx;
    logic             seg_legal;
    logic [3:0]       seg_nibble;

    assign grid_ok   = $onehot(~hex_grid_i);
    assign grid_same = (hex_grid_i == grid_prev_q);

    seg7_decode u_seg7_decode (
        .seg_i    (hex_seg_i[6:0]),
        .legal_o  (seg_legal),
        .nibble_o (seg_nibble)
    );

    // Digit position selected by the single low grid line.
    always_comb begin
        dig_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!hex_grid_i[i]) dig_idx = 2'(i);
        end
    end

    // Stability counter: cleared on any grid change or invalid grid, otherwise saturating count.
    always_comb begin
        cnt_d = cnt_q;
        if (!grid_ok || !grid_same) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Scan FSM next state; capture fires once per dwell on the settling edge.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grid_ok) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!grid_ok) begin
                    state_d = ST_IDLE;
                end else if (!grid_same) begin
                    state_d = ST_SETTLE;
                end else if (cnt_q == CNT_CAP) begin
                    state_d = ST_CAPTURED;
                    capture = 1'b1;
                end
            end
            ST_CAPTURED: begin
                if (!grid_ok)        state_d = ST_IDLE;
                else if (!grid_same) state_d = ST_SETTLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Shadow update on capture and frame publication once all four digits are seen.
    always_comb begin
        shadow_d = shadow_q;
        sdp_d    = sdp_q;
        seen_d   = seen_q;
        value_d  = value_q;
        dp_d     = dp_q;
        fv_d     = 1'b0;
        err_d    = 1'b0;
        if (capture) begin
            if (seg_legal) begin
                shadow_d[{dig_idx, 2'b00} +: 4] = seg_nibble;
                sdp_d[dig_idx]  = ~hex_seg_i[7];
                seen_d[dig_idx] = 1'b1;
                if (seen_d == 4'hF) begin
                    value_d = shadow_d;
                    dp_d    = sdp_d;
                    fv_d    = 1'b1;
                    seen_d  = 4'h0;
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // State registers; reset discards any partial frame.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= ST_IDLE;
            grid_prev_q <= 4'hF;
            cnt_q       <= '0;
            shadow_q    <= 16'h0000;
            sdp_q       <= 4'h0;
            seen_q      <= 4'h0;
            value_q     <= 16'h0000;
            dp_q        <= 4'h0;
            fv_q        <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            grid_prev_q <= hex_grid_i;
            cnt_q       <= cnt_d;
            shadow_q    <= shadow_d;
            sdp_q       <= sdp_d;
            seen_q      <= seen_d;
            value_q     <= value_d;
            dp_q        <= dp_d;
            fv_q        <= fv_d;
            err_q       <= err_d;
        end
    end

    assign value_o       = value_q;
    assign dp_o          = dp_q;
    assign frame_valid_o = fv_q;
    assign decode_err_o  = err_q;

endmodule

// File: tb/tb_hex_scan_decoder.sv
// Directed and randomized scan stimulus checked against a dwell-level reference model.
// Latency: model predicts outputs one cycle after each sampling edge.
// Backpressure: not applicable.
module tb_hex_scan_decoder;

    localparam int S = 4;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [7:0]  seg;
    logic [3:0]  grid;
    logic [15:0] value_o;
    logic [3:0]  dp_o;
    logic        frame_valid_o;
    logic        decode_err_o;

    always #5 Clk = ~Clk;

    hex_scan_decoder #(.SETTLE_CYCLES(S)) dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .hex_seg_i     (seg),
        .hex_grid_i    (grid),
        .value_o       (value_o),
        .dp_o          (dp_o),
        .frame_valid_o (frame_valid_o),
        .decode_err_o  (decode_err_o)
    );

    logic [7:0] glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    int total = 0;
    int passed = 0;
    int failed = 0;
    int fv_seen = 0;
    int err_seen = 0;

    // Reference model: tracks how long the current valid grid has been held.
    int          m_run;
    logic [3:0]  m_prev;
    logic [3:0]  m_digit [4];
    logic [3:0]  m_dpd;
    logic [3:0]  m_seen;
    logic [15:0] m_val;
    logic [3:0]  m_dp;
    logic        m_fv;
    logic        m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run  = 0;
        m_prev = 4'hF;
        for (int i = 0; i < 4; i++) m_digit[i] = 4'h0;
        m_dpd  = 4'h0;
        m_seen = 4'h0;
        m_val  = 16'h0000;
        m_dp   = 4'h0;
        m_fv   = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic model_edge(input logic [3:0] g, input logic [7:0] s);
        bit valid;
        bit found;
        int idx;
        int nib;
        valid = ($countones(~g) == 1);
        if (valid && g == m_prev) begin
            if (m_run < 1000) m_run++;
        end else if (valid) begin
            m_run = 1;
        end else begin
            m_run = 0;
        end
        m_fv  = 1'b0;
        m_err = 1'b0;
        if (m_run == S) begin
            idx = 0;
            for (int i = 0; i < 4; i++) if (!g[i]) idx = i;
            found = 0;
            nib = 0;
            for (int k = 0; k < 16; k++) begin
                if (glyph[k][6:0] == s[6:0]) begin
                    found = 1;
                    nib = k;
                end
            end
            if (found) begin
                m_digit[idx] = 4'(nib);
                m_dpd[idx]   = ~s[7];
                m_seen[idx]  = 1'b1;
                if (m_seen == 4'hF) begin
                    m_val  = {m_digit[3], m_digit[2], m_digit[1], m_digit[0]};
                    m_dp   = m_dpd;
                    m_fv   = 1'b1;
                    m_seen = 4'h0;
                end
            end else begin
                m_err = 1'b1;
            end
        end
        m_prev = g;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".value"}, 32'(value_o), 32'(m_val));
        check({tag, ".dp"}, 32'(dp_o), 32'(m_dp));
        check({tag, ".frame_valid"}, 32'(frame_valid_o), 32'(m_fv));
        check({tag, ".decode_err"}, 32'(decode_err_o), 32'(m_err));
    endtask

    // One sampling edge: drive at negedge, model at posedge, compare at next negedge.
    task automatic step(input logic [3:0] g, input logic [7:0] s, input string tag);
        grid = g;
        seg  = s;
        @(posedge Clk);
        model_edge(g, s);
        @(negedge Clk);
        check_all(tag);
        if (frame_valid_o) fv_seen++;
        if (decode_err_o)  err_seen++;
    endtask

    task automatic dwell(input logic [3:0] g, input logic [7:0] s, input int n, input string tag);
        for (int i = 0; i < n; i++) step(g, s, tag);
    endtask

    function automatic logic [3:0] dig(input int d);
        logic [3:0] g;
        g = 4'hF;
        g[d] = 1'b0;
        return g;
    endfunction

    initial begin
        logic [3:0] rg;
        logic [7:0] rs;
        int         rsel;

        // Reset state
        Reset_n = 1'b0;
        grid = 4'hF;
        seg  = 8'hFF;
        model_reset();
        repeat (2) @(negedge Clk);
        check_all("reset");
        Reset_n = 1'b1;

        // Basic frame 1,2,3,4
        fv_seen = 0;
        dwell(dig(0), 8'hF9, 8, "scan_d0");
        dwell(dig(1), 8'hA4, 8, "scan_d1");
        dwell(dig(2), 8'hB0, 8, "scan_d2");
        dwell(dig(3), 8'h99, 8, "scan_d3");
        check("basic_value", 32'(value_o), 32'h4321);
        check("basic_dp", 32'(dp_o), 32'h0);
        check("basic_frames", fv_seen, 1);

        // Glitch on digit 2 ignored; full hold captures on the 4th edge
        fv_seen = 0;
        dwell(dig(0), 8'hC0, 6, "gl_d0");
        dwell(dig(1), 8'hF9, 6, "gl_d1");
        dwell(dig(3), 8'h86, 6, "gl_d3");
        dwell(dig(2), 8'h88, 3, "gl_short");
        dwell(4'hF, 8'hFF, 2, "gl_blank");
        check("glitch_no_frame", fv_seen, 0);
        dwell(dig(2), 8'h88, 3, "gl_hold");
        check("glitch_pre4", fv_seen, 0);
        step(dig(2), 8'h88, "gl_edge4");
        check("glitch_edge4_fv", 32'(frame_valid_o), 32'h1);
        check("glitch_value", 32'(value_o), 32'hEA10);
        dwell(4'hF, 8'hFF, 2, "gl_tail");

        // Illegal dp-only glyph then legal rescan as 8 with dp
        fv_seen = 0;
        err_seen = 0;
        dwell(dig(1), 8'h7F, 6, "ill_d1");
        check("illegal_err_count", err_seen, 1);
        dwell(dig(0), 8'h92, 6, "ill_d0");
        dwell(dig(2), 8'h82, 6, "ill_d2");
        dwell(dig(3), 8'hF8, 6, "ill_d3");
        check("illegal_no_frame", fv_seen, 0);
        dwell(dig(1), 8'h00, 6, "ill_fix");
        check("fix_frames", fv_seen, 1);
        check("fix_dp1", 32'(dp_o[1]), 32'h1);
        check("fix_nibble1", 32'(value_o[7:4]), 32'h8);
        check("fix_value", 32'(value_o), 32'h7685);

        // Invalid grids interleaved between digits
        fv_seen = 0;
        dwell(dig(0), 8'hC0, 6, "iv_d0");
        dwell(4'b1100, 8'hA4, 5, "iv_multi");
        dwell(dig(1), 8'hA4, 3, "iv_short");
        dwell(4'hF, 8'hFF, 2, "iv_blank");
        dwell(dig(1), 8'hA4, 6, "iv_d1");
        dwell(4'hF, 8'hFF, 2, "iv_blank2");
        dwell(dig(2), 8'h90, 6, "iv_d2");
        dwell(4'b1100, 8'h90, 3, "iv_multi2");
        dwell(dig(3), 8'hA1, 6, "iv_d3");
        check("interleave_frames", fv_seen, 1);
        check("interleave_value", 32'(value_o), 32'hD920);

        // Asynchronous reset mid-scan discards the partial frame
        dwell(dig(0), 8'h8E, 6, "rst_d0");
        dwell(dig(1), 8'h8E, 6, "rst_d1");
        dwell(dig(2), 8'h8E, 6, "rst_d2");
        #2;
        Reset_n = 1'b0;
        grid = 4'hF;
        seg  = 8'hFF;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge Clk);
        Reset_n = 1'b1;
        fv_seen = 0;
        dwell(dig(0), 8'hC0, 6, "post_d0");
        dwell(dig(1), 8'hC0, 6, "post_d1");
        dwell(dig(2), 8'hC0, 6, "post_d2");
        dwell(dig(3), 8'hC6, 6, "post_d3");
        check("post_rst_value", 32'(value_o), 32'hC000);
        check("post_rst_frames", fv_seen, 1);

        // Digit 0 rescanned before the frame completes: last write wins
        fv_seen = 0;
        dwell(dig(0), 8'hF9, 6, "rw_d0a");
        dwell(4'hF, 8'hFF, 2, "rw_blank");
        dwell(dig(0), 8'h8E, 6, "rw_d0b");
        dwell(dig(1), 8'hC0, 6, "rw_d1");
        dwell(dig(2), 8'hC0, 6, "rw_d2");
        dwell(dig(3), 8'hC0, 6, "rw_d3");
        check("rewrite_nibble0", 32'(value_o[3:0]), 32'hF);
        check("rewrite_frames", fv_seen, 1);

        // Randomized dwells
        for (int n = 0; n < 200; n++) begin
            rsel = int'($urandom_range(0, 9));
            if (rsel < 7)       rg = dig(int'($urandom_range(0, 3)));
            else if (rsel == 7) rg = 4'hF;
            else                rg = 4'($urandom);
            if ($urandom_range(0, 9) < 7) begin
                rs = glyph[$urandom_range(0, 15)];
                rs[7] = 1'($urandom);
            end else begin
                rs = 8'($urandom);
            end
            dwell(rg, rs, int'($urandom_range(1, 8)), "rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
